alu_result_monitor: RTL and testbench

// Observes the tinyalu command/response interface (start, op, A, B, done, result) alongside the stimulus driver.

---
 rtl/alu_bfm_pkg.sv | 37 +++
 rtl/alu_cmd_tracker.sv | 55 +++++
 rtl/alu_result_monitor.sv | 108 ++++++++++
 tb/tb_alu_result_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bfm_pkg.sv
// Shared tinyalu opcode enum and record layout, used by the result monitor and
// the stimulus driver so both sides agree on how a record is packed.
package alu_bfm_pkg;

  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4
  } alu_op_e;

  localparam int OP_LSB        = 0;
  localparam int OP_WIDTH      = 3;
  localparam int PAD_LSB       = 3;
  localparam int PAD_WIDTH     = 5;
  localparam int A_LSB         = 8;
  localparam int A_WIDTH       = 8;
  localparam int B_LSB         = 16;
  localparam int B_WIDTH       = 8;
  localparam int RESULT_LSB    = 24;
  localparam int RESULT_WIDTH  = 16;
  localparam int CMD_REC_WIDTH = RESULT_LSB;
  localparam int RECORD_WIDTH  = RESULT_LSB + RESULT_WIDTH;

  // Only real ALU operations produce a record; NO_OP and undefined codes are ignored.
  function automatic logic op_is_recordable(input logic [OP_WIDTH-1:0] op);
    return op inside {ADD, AND, XOR, MUL};
  endfunction

  function automatic logic [CMD_REC_WIDTH-1:0] pack_cmd(input logic [OP_WIDTH-1:0] op,
                                                        input logic [A_WIDTH-1:0]  a,
                                                        input logic [B_WIDTH-1:0]  b);
    return {b, a, {PAD_WIDTH{1'b0}}, op};
  endfunction

endpackage

// File: rtl/alu_cmd_tracker.sv
// Tracks the single outstanding tinyalu command: captures op/A/B on start,
// reports its completion, spurious done strobes and abandoned commands.
module alu_cmd_tracker
  import alu_bfm_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [OP_WIDTH-1:0]      op,
  input  logic [A_WIDTH-1:0]       A,
  input  logic [B_WIDTH-1:0]       B,
  input  logic                     done,
  output logic                     cmd_fire,
  output logic [CMD_REC_WIDTH-1:0] cmd_rec,
  output logic                     spurious,
  output logic                     timeout
);

  localparam int TIMER_W = $clog2(TIMEOUT);

  logic                     pending;
  logic [TIMER_W-1:0]       timer;
  logic [CMD_REC_WIDTH-1:0] cmd_q;
  logic                     capture;

  // done on the expiry cycle still completes the command, so expiry requires !done.
  assign cmd_fire = done && pending;
  assign spurious = done && !pending;
  assign timeout  = pending && !done && (timer == TIMER_W'(TIMEOUT - 1));
  assign capture  = start && !pending && op_is_recordable(op);
  assign cmd_rec  = cmd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      timer   <= '0;
      cmd_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (capture) begin
        pending <= 1'b1;
        timer   <= '0;
        cmd_q   <= pack_cmd(op, A, B);
      end else if (cmd_fire || timeout) begin
        pending <= 1'b0;
        timer   <= '0;
      end else if (pending) begin
        timer   <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_result_monitor.sv
// Pairs tinyalu commands with their results and packs the records into one wide
// package word that the harness reads back with a valid/ack handshake.
module alu_result_monitor
  import alu_bfm_pkg::*;
#(
  parameter int NUM           = 100,
  parameter int PACKAGE_WIDTH = 4000,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [7:0]               A,
  input  logic [7:0]               B,
  input  logic                     done,
  input  logic [15:0]              result,
  input  logic                     flush,
  input  logic                     pkg_ack,
  output logic [PACKAGE_WIDTH-1:0] pkg_data,
  output logic                     pkg_valid,
  output logic [$clog2(NUM+1)-1:0] pkg_count,
  output logic [15:0]              drop_cnt,
  output logic [1:0]               err_flags
);

  localparam int CNT_W = $clog2(NUM + 1);
  localparam int OFF_W = $clog2(PACKAGE_WIDTH);

  if (PACKAGE_WIDTH != NUM * RECORD_WIDTH) begin : g_width_check
    $error("PACKAGE_WIDTH must equal NUM * RECORD_WIDTH");
  end

  logic                     cmd_fire;
  logic [CMD_REC_WIDTH-1:0] cmd_rec;
  logic                     spurious;
  logic                     timeout;

  alu_cmd_tracker #(
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .done     (done),
    .cmd_fire (cmd_fire),
    .cmd_rec  (cmd_rec),
    .spurious (spurious),
    .timeout  (timeout)
  );

  logic [CNT_W-1:0]         wr_idx;
  logic [CNT_W-1:0]         base_idx;
  logic [CNT_W-1:0]         idx_next;
  logic [OFF_W-1:0]         wr_off;
  logic [PACKAGE_WIDTH-1:0] data_next;
  logic                     ack;
  logic                     can_write;
  logic                     drop;
  logic                     publish;

  always_comb begin
    // NOTE: every signal gets a value before any condition, so no path can infer a latch.
    ack       = pkg_valid && pkg_ack;
    base_idx  = ack ? '0 : wr_idx;
    can_write = cmd_fire && (ack || (!pkg_valid && (wr_idx != CNT_W'(NUM))));
    drop      = cmd_fire && !can_write;
    idx_next  = base_idx + CNT_W'(can_write);
    wr_off    = OFF_W'(base_idx) * OFF_W'(RECORD_WIDTH);
    data_next = ack ? '0 : pkg_data;
    if (can_write) begin
      data_next[wr_off +: RECORD_WIDTH] = {result, cmd_rec};
    end
    // A full buffer publishes on the edge after its last write; a flush publishes on the
    // edge it is sampled and counts a record completing on that same edge.
    publish = !pkg_valid && ((wr_idx == CNT_W'(NUM)) || (flush && (idx_next != '0)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the record buffer is reset as well, so a discarded partial package reads back as zeros.
      pkg_data  <= '0;
      pkg_valid <= 1'b0;
      pkg_count <= '0;
      wr_idx    <= '0;
      drop_cnt  <= '0;
      err_flags <= '0;
    end else begin
      pkg_data <= data_next;
      wr_idx   <= idx_next;
      if (ack) begin
        pkg_valid <= 1'b0;
        pkg_count <= '0;
      end else if (publish) begin
        pkg_valid <= 1'b1;
        pkg_count <= idx_next;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      err_flags <= err_flags | {timeout, spurious};
    end
  end

endmodule

// File: tb/tb_alu_result_monitor.sv
// Self-checking bench for alu_result_monitor: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_alu_result_monitor;

  localparam int NUM = 100;
  localparam int RW  = 40;
  localparam int PW  = NUM * RW;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [7:0]    A = '0;
  logic [7:0]    B = '0;
  logic          done = 1'b0;
  logic [15:0]   result = '0;
  logic          flush = 1'b0;
  logic          pkg_ack = 1'b0;
  logic [PW-1:0] pkg_data;
  logic          pkg_valid;
  logic [6:0]    pkg_count;
  logic [15:0]   drop_cnt;
  logic [1:0]    err_flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_monitor #(.NUM(NUM), .PACKAGE_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .done      (done),
    .result    (result),
    .flush     (flush),
    .pkg_ack   (pkg_ack),
    .pkg_data  (pkg_data),
    .pkg_valid (pkg_valid),
    .pkg_count (pkg_count),
    .drop_cnt  (drop_cnt),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [RW-1:0] m_slots [NUM];
  int            m_idx;
  bit            m_valid;
  int            m_count;
  logic [15:0]   m_drop;
  logic [1:0]    m_err;
  bit            m_pending;
  logic [2:0]    m_op;
  logic [7:0]    m_a;
  logic [7:0]    m_b;
  int            m_cap_cycle;
  int            m_cycle;

  task automatic model_reset();
    for (int k = 0; k < NUM; k++) m_slots[k] = '0;
    m_idx = 0; m_valid = 0; m_count = 0; m_drop = '0; m_err = '0;
    m_pending = 0; m_op = '0; m_a = '0; m_b = '0; m_cap_cycle = 0; m_cycle = 0;
  endtask

  task automatic model_step();
    bit fire, expire, capture, was_valid, was_full;
    fire      = done && m_pending;
    expire    = m_pending && !done && (m_cycle - m_cap_cycle == TO);
    capture   = start && !m_pending && (op >= 3'd1) && (op <= 3'd4);
    was_valid = m_valid;
    was_full  = (m_idx == NUM);
    if (done && !m_pending) m_err[0] = 1'b1;
    if (expire) m_err[1] = 1'b1;
    if (m_valid && pkg_ack) begin
      for (int k = 0; k < NUM; k++) m_slots[k] = '0;
      m_idx = 0; m_valid = 0; m_count = 0;
    end
    if (fire) begin
      if (!m_valid && m_idx < NUM) begin
        m_slots[m_idx] = {result, m_b, m_a, 5'b0, m_op};
        m_idx++;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
    if (!was_valid && (was_full || (flush && m_idx > 0))) begin
      m_valid = 1; m_count = m_idx;
    end
    if (fire || expire) m_pending = 0;
    if (capture) begin
      m_pending = 1; m_op = op; m_a = A; m_b = B; m_cap_cycle = m_cycle;
    end
    m_cycle++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_data();
    logic [PW-1:0] exp;
    exp = '0;
    for (int k = 0; k < NUM; k++) exp[k*RW +: RW] = m_slots[k];
    n_checks++;
    if (pkg_data !== exp) begin
      n_errors++;
      for (int k = 0; k < NUM; k++) begin
        if (pkg_data[k*RW +: RW] !== exp[k*RW +: RW]) begin
          $display("FAIL pkg_data slot %0d: got %h expected %h at %0t",
                   k, pkg_data[k*RW +: RW], exp[k*RW +: RW], $time);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("pkg_valid", pkg_valid, m_valid);
      check("pkg_count", pkg_count, m_count);
      check("drop_cnt", drop_cnt, m_drop);
      check("err_flags", err_flags, m_err);
      check_data();
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] alu_ref(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Capture on the next edge, then done sampled exactly lat edges later.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input int lat, input bit hold, input bit with_flush, input bit with_ack);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    repeat (lat - 1) begin @(posedge clk); #1; end
    done = 1'b1; result = alu_ref(o, a, b); flush = with_flush; pkg_ack = with_ack;
    @(posedge clk); #1;
    done = 1'b0; flush = 1'b0; pkg_ack = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic pulse_ack();
    pkg_ack = 1'b1; @(posedge clk); #1; pkg_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", pkg_valid, 1'b0);
    check("reset_data_zero", pkg_data == '0, 1'b1);
    check("reset_err", err_flags, 2'b00);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single ADD, visible one cycle after done, not yet published
    issue(3'd1, 8'h12, 8'h34, 1, 0, 0, 0);
    check("t1_slot0", pkg_data[39:0], 40'h0046_34_12_01);
    check("t1_model_slot0", m_slots[0], 40'h0046_34_12_01);
    check("t1_count", pkg_count, 7'd0);
    check("t1_valid", pkg_valid, 1'b0);
    pulse_flush();
    check("t1_flush_count", pkg_count, 7'd1);
    pulse_ack();
    check("t1_ack_clear", pkg_data == '0, 1'b1);

    // 2: 100 back-to-back XOR with start held high
    a = '0; b = '0;
    for (int i = 0; i < NUM; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      issue(3'd3, a, b, 1, i != NUM - 1, 0, 0);
    end
    check("t2_valid_late", pkg_valid, 1'b0);
    check("t2_slot99", pkg_data[99*RW +: RW], {alu_ref(3'd3, a, b), b, a, 8'h03});
    @(posedge clk); #1;
    check("t2_valid", pkg_valid, 1'b1);
    check("t2_count", pkg_count, 7'd100);
    check("t2_drop", drop_cnt, 16'd0);

    // 3: drops while held, then ack coinciding with a completion
    for (int i = 0; i < 3; i++) issue(3'd3, 8'($urandom), 8'($urandom), 2, 0, 0, 0);
    check("t3_drop3", drop_cnt, 16'd3);
    check("t3_still_valid", pkg_valid, 1'b1);
    a = 8'hA5; b = 8'h3C;
    issue(3'd3, a, b, 1, 0, 0, 1);
    check("t3_ack_slot0", pkg_data[39:0], 40'h0099_3C_A5_03);
    check("t3_ack_valid", pkg_valid, 1'b0);
    check("t3_ack_drop", drop_cnt, 16'd3);

    // Done on the expiry cycle wins: record written, no error
    issue(3'd4, 8'h10, 8'h10, TO, 0, 0, 0);
    check("expiry_done_slot1", pkg_data[79:40], 40'h0100_10_10_04);
    check("expiry_done_err", err_flags, 2'b00);

    // 4: MUL abandoned, then a done with nothing pending
    start = 1'b1; op = 3'd4; A = 8'h07; B = 8'h09;
    @(posedge clk); #1; start = 1'b0;
    repeat (TO - 1) begin @(posedge clk); #1; end
    check("t4_before_timeout", err_flags, 2'b00);
    @(posedge clk); #1;
    check("t4_timeout", err_flags, 2'b10);
    done = 1'b1; result = 16'hDEAD;
    @(posedge clk); #1; done = 1'b0;
    check("t4_spurious", err_flags, 2'b11);
    check("t4_no_record", pkg_data[119:80], 40'h0);

    // 5: empty flush ignored; 5 records with flush on the last completion
    pulse_flush();
    check("t5_flush2_count", pkg_count, 7'd2);
    pulse_ack();
    pulse_flush();
    check("t5_empty_flush", pkg_valid, 1'b0);
    issue(3'd0, 8'h01, 8'h02, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) issue(3'($urandom_range(1, 4)), 8'($urandom), 8'($urandom), 3, 0, 0, 0);
    issue(3'd2, 8'hF0, 8'h3C, 1, 0, 1, 0);
    check("t5_valid", pkg_valid, 1'b1);
    check("t5_count", pkg_count, 7'd5);
    check("t5_slot4", pkg_data[199:160], 40'h0030_3C_F0_02);
    check("t5_upper_zero", pkg_data[PW-1:5*RW] == '0, 1'b1);
    pulse_ack();

    // 6: async reset mid-package
    for (int i = 0; i < 7; i++) issue(3'($urandom_range(1, 4)), 8'($urandom), 8'($urandom), 1, 0, 0, 0);
    @(posedge clk); #2; reset_n = 1'b0; #1;
    check("t6_data_zero", pkg_data == '0, 1'b1);
    check("t6_err_zero", err_flags, 2'b00);
    check("t6_drop_zero", drop_cnt, 16'd0);
    check("t6_valid_zero", pkg_valid, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd1, 8'hFF, 8'h01, 1, 0, 0, 0);
    check("t6_slot0", pkg_data[39:0], 40'h0100_01_FF_01);

    // Randomized traffic: busy phase, then sparse done to provoke timeouts
    for (int phase = 0; phase < 2; phase++) begin
      for (int cyc = 0; cyc < 2500; cyc++) begin
        start   = ($urandom_range(0, 99) < 50);
        op      = 3'($urandom_range(0, 7));
        A       = 8'($urandom);
        B       = 8'($urandom);
        done    = ($urandom_range(0, 99) < (phase == 0 ? 30 : 1));
        result  = 16'($urandom);
        flush   = ($urandom_range(0, 99) < 3);
        pkg_ack = ($urandom_range(0, 99) < 6);
        @(posedge clk); #1;
      end
    end
    start = 1'b0; done = 1'b0; flush = 1'b0; pkg_ack = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
